motor_commander_uart: RTL and testbench

Translates the one-hot motor command from the drive-control logic into fixed-length ASCII command strings for the motor driver board. It sends each string byte by byte over a valid/ready UART-transmit stream. The block sits between the motor state machine and the UART transmitter. It emits a new string whenever the requested motion changes.

---
 rtl/motor_commander_pkg.sv | 48 ++++
 rtl/motor_cmd_rom.sv | 32 +++
 rtl/motor_commander_uart.sv | 152 +++++++++++++++
 tb/tb_motor_commander_uart.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_commander_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_commander_pkg
// Description : Shared types, the ASCII command-string table and the one-hot
//               motion decoder for motor_commander_uart.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_commander_pkg;

    // NONE is the reset value of last_cmd and never equals a decoded command
    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_STOP = 3'd1,
        CMD_FWD  = 3'd2,
        CMD_RGT  = 3'd3,
        CMD_LFT  = 3'd4,
        CMD_SPIN = 3'd5
    } cmd_e;

    localparam int N_INSTRS = 4;
    localparam int N_CMDS   = 6;

    // First character sits in the most significant byte
    localparam logic [8*N_INSTRS-1:0] CMD_STR [N_CMDS] = '{
        32'h0000_0000,       // CMD_NONE, never transmitted
        {"STP", 8'h0A},
        {"FWD", 8'h0A},
        {"RGT", 8'h0A},
        {"LFT", 8'h0A},
        {"SPN", 8'h0A}
    };

    // Anything that is not exactly one-hot falls back to STOP
    function automatic cmd_e decode_state(input logic [4:0] st);
        cmd_e cmd;
        case (st)
            5'b00001: cmd = CMD_STOP;
            5'b00010: cmd = CMD_FWD;
            5'b00100: cmd = CMD_RGT;
            5'b01000: cmd = CMD_LFT;
            5'b10000: cmd = CMD_SPIN;
            default:  cmd = CMD_STOP;
        endcase
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_cmd_rom.sv
`default_nettype none
// ============================================================================
// Module      : motor_cmd_rom
// Description : Combinational lookup of one byte of a command string,
//               selected by command code and byte index.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_cmd_rom
    import motor_commander_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  cmd_e             cmd,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       byte_out
);

    logic [8*N_INSTRS-1:0] word;

    // Select the string word, then the byte at position idx (first char first)
    always_comb begin
        word     = (int'(cmd) < N_CMDS) ? CMD_STR[cmd] : '0;
        byte_out = 8'h00;
        for (int i = 0; i < N_INSTRS; i++) begin
            if (idx == IDX_W'(i)) begin
                byte_out = word[8*(N_INSTRS-1-i) +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_commander_uart.sv
`default_nettype none
// ============================================================================
// Module      : motor_commander_uart
// Description : Turns the one-hot motor request into fixed-length ASCII
//               command strings sent over a valid/ready byte stream.
//               Optional macro MOTOR_CMD_HEARTBEAT_EN adds a periodic resend
//               of the last command after REPEAT_CYCLES idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_commander_uart
    import motor_commander_pkg::*;
#(
    parameter int N_INSTRS      = 4,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] motor_state,
    input  logic       uart_tx_ready,
    output logic       uart_tx_valid,
    output logic [7:0] uart_tx_data
);

    localparam int IDX_W = (N_INSTRS > 1) ? $clog2(N_INSTRS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INSTRS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cmd_e             cur_cmd_q, cur_cmd_d;
    cmd_e             last_cmd_q, last_cmd_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;

    cmd_e             dec_cmd;
    logic             cmd_change;
    logic             hb_fire;
    cmd_e             rom_cmd;
    logic [IDX_W-1:0] rom_idx;
    logic [7:0]       rom_byte;

    assign dec_cmd    = decode_state(motor_state);
    assign cmd_change = (dec_cmd != last_cmd_q);

`ifdef MOTOR_CMD_HEARTBEAT_EN
    logic [31:0] hb_q, hb_d;

    assign hb_fire = (hb_q == 32'(REPEAT_CYCLES - 1));

    // Idle counter: runs only while idle and restarts whenever a string starts
    always_comb begin
        hb_d = hb_q + 32'd1;
        if (state_q != ST_IDLE || cmd_change || hb_fire) begin
            hb_d = 32'd0;
        end
    end

    // Heartbeat counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_q <= 32'd0;
        end else begin
            hb_q <= hb_d;
        end
    end
`else
    assign hb_fire = 1'b0;
`endif

    // ROM address: byte 0 of the command about to start, or the next byte in flight
    always_comb begin
        rom_cmd = cur_cmd_q;
        rom_idx = idx_q + IDX_W'(1);
        if (state_q == ST_IDLE) begin
            rom_cmd = cmd_change ? dec_cmd : last_cmd_q;
            rom_idx = '0;
        end
    end

    motor_cmd_rom #(
        .IDX_W    (IDX_W)
    ) u_rom (
        .cmd      (rom_cmd),
        .idx      (rom_idx),
        .byte_out (rom_byte)
    );

    // Next-state logic; outputs are loaded one cycle ahead so they come straight from flops
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_cmd_d  = cur_cmd_q;
        last_cmd_d = last_cmd_q;
        valid_d    = valid_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_change || hb_fire) begin
                    // A command change wins over a heartbeat resend
                    cur_cmd_d  = cmd_change ? dec_cmd : last_cmd_q;
                    last_cmd_d = cmd_change ? dec_cmd : last_cmd_q;
                    idx_d      = '0;
                    valid_d    = 1'b1;
                    data_d     = rom_byte;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (uart_tx_ready) begin
                    if (idx_q == IDX_LAST) begin
                        valid_d = 1'b0;
                        data_d  = 8'h00;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = rom_byte;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any string in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cur_cmd_q  <= CMD_NONE;
            last_cmd_q <= CMD_NONE;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_cmd_q  <= cur_cmd_d;
            last_cmd_q <= last_cmd_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign uart_tx_valid = valid_q;
    assign uart_tx_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_commander_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_commander_uart
// Description : Directed self-checking bench for motor_commander_uart.
//               Define MOTOR_CMD_HEARTBEAT_EN to exercise the resend feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_commander_uart;

`ifdef MOTOR_CMD_HEARTBEAT_EN
    localparam int REP = 8;
`else
    localparam int REP = 50_000_000;
`endif

    localparam logic [31:0] S_STP = {"STP", 8'h0A};
    localparam logic [31:0] S_FWD = {"FWD", 8'h0A};
    localparam logic [31:0] S_RGT = {"RGT", 8'h0A};
    localparam logic [31:0] S_LFT = {"LFT", 8'h0A};
    localparam logic [31:0] S_SPN = {"SPN", 8'h0A};

    logic       clk;
    logic       reset;
    logic [4:0] motor_state;
    logic       uart_tx_ready;
    logic       uart_tx_valid;
    logic [7:0] uart_tx_data;

    int checks;
    int errors;
    logic [7:0] rxq[$];

    motor_commander_uart #(
        .N_INSTRS      (4),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .motor_state   (motor_state),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bytes that will be accepted on the coming rising edge
    always @(negedge clk) begin
        if (reset && uart_tx_valid && uart_tx_ready) begin
            rxq.push_back(uart_tx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_str(input string tag, input logic [31:0] exp);
        int waited;
        logic [31:0] got;
        waited = 0;
        while (rxq.size() < 4 && waited < 200) begin
            tick();
            waited++;
        end
        if (rxq.size() < 4) begin
            check({tag, "_timeout"}, 32'(rxq.size()), 32'd4);
        end else begin
            got = {rxq[0], rxq[1], rxq[2], rxq[3]};
            repeat (4) void'(rxq.pop_front());
            check(tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int waited;
        waited = 0;
        while (!uart_tx_valid && waited < 200) begin
            tick();
            waited++;
        end
        if (!uart_tx_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int gap;
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        motor_state   = 5'b00001;
        uart_tx_ready = 1'b1;
        tick(3);
        check("rst_valid", 32'(uart_tx_valid), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'h00);

        // First STOP after reset release, one byte per cycle
        reset = 1'b1;
        tick();
        check("boot_b0_valid", 32'(uart_tx_valid), 32'd1);
        check("boot_b0", 32'(uart_tx_data), 32'h53);
        tick();
        check("boot_b1", 32'(uart_tx_data), 32'h54);
        tick();
        check("boot_b2", 32'(uart_tx_data), 32'h50);
        tick();
        check("boot_b3", 32'(uart_tx_data), 32'h0A);
        check("boot_b3_valid", 32'(uart_tx_valid), 32'd1);
        tick();
        check("boot_end_valid", 32'(uart_tx_valid), 32'd0);
        rxq.delete();

`ifdef MOTOR_CMD_HEARTBEAT_EN
        // Idle gap before the resend, then repeated STOP strings
        gap = 1;
        tick();
        while (!uart_tx_valid && gap < 50) begin
            gap++;
            tick();
        end
        check("hb_gap", 32'(gap), 32'd8);
        expect_str("hb_rep1", S_STP);
        expect_str("hb_rep2", S_STP);
`else
        gap = 0;
        tick(10);
        check("boot_no_repeat", 32'(rxq.size()), 32'd0);

        // Each direction held for 10 cycles
        motor_state = 5'b00010; tick(10);
        motor_state = 5'b00100; tick(10);
        motor_state = 5'b01000; tick(10);
        motor_state = 5'b10000; tick(10);
        expect_str("seq_fwd", S_FWD);
        expect_str("seq_rgt", S_RGT);
        expect_str("seq_lft", S_LFT);
        expect_str("seq_spn", S_SPN);

        // Backpressure in the middle of a string
        motor_state = 5'b00001;
        tick(2);
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(uart_tx_valid), 32'd1);
            check("stall_data", 32'(uart_tx_data), 32'h54);
            tick();
        end
        uart_tx_ready = 1'b1;
        expect_str("stall_str", S_STP);
        tick(3);
        check("stall_no_extra", 32'(rxq.size()), 32'd0);

        // Two changes during a string: only the final one follows
        motor_state = 5'b00010;
        tick();
        motor_state = 5'b00100;
        tick();
        motor_state = 5'b01000;
        tick(15);
        expect_str("chg_first", S_FWD);
        expect_str("chg_final", S_LFT);
        check("chg_no_extra", 32'(rxq.size()), 32'd0);

        // Multi-hot and zero requests decode to STOP
        motor_state = 5'b00010; tick(8);
        expect_str("mh_pre_fwd", S_FWD);
        motor_state = 5'b00110; tick(8);
        expect_str("multihot_stp", S_STP);
        motor_state = 5'b00010; tick(8);
        expect_str("zero_pre_fwd", S_FWD);
        motor_state = 5'b00000; tick(8);
        expect_str("zero_stp", S_STP);
`endif

        // Reset in the middle of a string drops valid without waiting for a clock
        motor_state = 5'b00010;
        tick();
        wait_valid("mid_wait");
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(uart_tx_valid), 32'd0);
        check("midrst_data", 32'(uart_tx_data), 32'h00);
        tick(2);
        rxq.delete();
        motor_state = 5'b00001;
        reset = 1'b1;
        expect_str("post_rst_stp", S_STP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
